// File: rtl/pe_pkg.sv
// ============================================================================
//  pe_pkg : shared FSM state type and width helpers for the IFMAP window
//  address generator.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package pe_pkg;

   localparam int C_CONFIG_BIT_DEF = 4;
   localparam int C_NUM_OF_REG_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter width: holds base + stride without overflow.
   function automatic int cnt_w(input int cfg_bit);
      return cfg_bit + 1;
   endfunction

   // Limit width: holds ifmap_len - filt_len + 1 for the end-of-map compare.
   function automatic int lim_w(input int cfg_bit);
      return cfg_bit + 2;
   endfunction

   function automatic int sum_w(input int addr_w, input int cfg_bit);
      return addr_w + cfg_bit + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/base_stride_counter.sv
// ============================================================================
//  base_stride_counter : loadable counter with clear, step-by-stride increment
//  and a registered "count + step >= limit" look-ahead flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module base_stride_counter #(
   parameter int W  = 5,
   parameter int LW = W + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic          clr_i,
   input  logic          inc_i,
   input  logic [W-1:0]  step_i,
   input  logic [LW-1:0] limit_i,
   output logic [W-1:0]  count_o,
   output logic          nxt_ge_o
);

   localparam int CW = LW + 2;

   logic [W-1:0]  count_q, count_d;
   logic [W-1:0]  step_q, step_d;
   logic [LW-1:0] limit_q, limit_d;
   logic          nxt_ge_q, nxt_ge_d;

   // The flag always describes the value the counter would take on the next
   // increment, so it is ready in the same cycle the counter is consulted.
   always_comb begin
      count_d  = count_q;
      step_d   = step_q;
      limit_d  = limit_q;
      nxt_ge_d = nxt_ge_q;
      if (load_i) begin
         count_d  = '0;
         step_d   = step_i;
         limit_d  = limit_i;
         nxt_ge_d = CW'(step_i) >= CW'(limit_i);
      end else if (clr_i) begin
         count_d  = '0;
         nxt_ge_d = CW'(step_q) >= CW'(limit_q);
      end else if (inc_i) begin
         count_d  = count_q + step_q;
         nxt_ge_d = (CW'(count_q) + CW'(step_q) + CW'(step_q)) >= CW'(limit_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         step_q   <= '0;
         limit_q  <= '0;
         nxt_ge_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         step_q   <= step_d;
         limit_q  <= limit_d;
         nxt_ge_q <= nxt_ge_d;
      end
   end

   assign count_o  = count_q;
   assign nxt_ge_o = nxt_ge_q;

endmodule

`default_nettype wire

// File: rtl/ifmap_window_addr_gen.sv
// ============================================================================
//  ifmap_window_addr_gen : walks a 1-D convolution window over a circular IFMAP
//  scratchpad, one address per handshake. Optional win_idx: IFMAP_WIN_CNT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ifmap_window_addr_gen
   import pe_pkg::*;
#(
   parameter int CONFIG_BIT = C_CONFIG_BIT_DEF,
   parameter int NUM_OF_REG = C_NUM_OF_REG_DEF,
   parameter int ADDR_W     = $clog2(NUM_OF_REG)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic [CONFIG_BIT-1:0] ifmap_len,
   input  logic [CONFIG_BIT-1:0] filt_len,
   input  logic [CONFIG_BIT-1:0] stride,
   output logic                  addr_valid,
   input  logic                  addr_ready,
   output logic [ADDR_W-1:0]     addr_out,
   output logic                  win_last,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
`ifdef IFMAP_WIN_CNT_EN
  ,output logic [CONFIG_BIT-1:0] win_idx
`endif
);

   localparam int CNT_W = cnt_w(CONFIG_BIT);
   localparam int LIM_W = lim_w(CONFIG_BIT);
   localparam int SUM_W = sum_w(ADDR_W, CONFIG_BIT);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] start_addr_q;
   logic              cfg_err_q, cfg_err_d;
   logic [CNT_W-1:0]  base_cnt, off_cnt;
   logic              base_ge, off_last;
   logic              start_acc, illegal, hs, win_end;
   logic [LIM_W-1:0]  base_limit;

   assign start_acc  = (state_q == ST_IDLE) && start;
   assign illegal    = (filt_len == '0) || (stride == '0) || (filt_len > ifmap_len);
   assign hs         = addr_valid && addr_ready;
   assign win_end    = hs && win_last;
   // base_n + filt_len > ifmap_len  <=>  base_n >= ifmap_len - filt_len + 1
   assign base_limit = LIM_W'(ifmap_len) - LIM_W'(filt_len) + LIM_W'(1);

   base_stride_counter #(.W(CNT_W), .LW(LIM_W)) u_base (
      .clk      (clk),
      .rst      (rst),
      .load_i   (start_acc),
      .clr_i    (1'b0),
      .inc_i    (win_end),
      .step_i   (CNT_W'(stride)),
      .limit_i  (base_limit),
      .count_o  (base_cnt),
      .nxt_ge_o (base_ge)
   );

   base_stride_counter #(.W(CNT_W), .LW(LIM_W)) u_offset (
      .clk      (clk),
      .rst      (rst),
      .load_i   (start_acc),
      .clr_i    (win_end),
      .inc_i    (hs && !win_last),
      .step_i   (CNT_W'(1)),
      .limit_i  (LIM_W'(filt_len)),
      .count_o  (off_cnt),
      .nxt_ge_o (off_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cfg_err_d = cfg_err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cfg_err_d = illegal;
               state_d   = illegal ? ST_DONE : ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (win_end && base_ge) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      addr_valid = (state_q == ST_EMIT);
      busy       = (state_q == ST_EMIT);
      done       = (state_q == ST_DONE);
      win_last   = (state_q == ST_EMIT) && off_last;
      addr_out   = ADDR_W'(SUM_W'(start_addr_q) + SUM_W'(base_cnt) + SUM_W'(off_cnt));
      cfg_err    = cfg_err_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_addr_q <= '0;
         cfg_err_q    <= 1'b0;
      end else begin
         cfg_err_q <= cfg_err_d;
         if (start_acc) begin
            start_addr_q <= start_addr;
         end
      end
   end

`ifdef IFMAP_WIN_CNT_EN
   logic [CONFIG_BIT-1:0] win_idx_q, win_idx_d;

   always_comb begin
      win_idx_d = win_idx_q;
      if (start_acc) begin
         win_idx_d = '0;
      end else if (win_end && (win_idx_q != '1)) begin
         win_idx_d = win_idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_idx_q <= '0;
      end else begin
         win_idx_q <= win_idx_d;
      end
   end

   assign win_idx = win_idx_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifmap_window_addr_gen.sv
// ============================================================================
//  tb_ifmap_window_addr_gen : directed self-checking bench for the IFMAP
//  window address generator.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ifmap_window_addr_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] start_addr = '0;
   logic [3:0] ifmap_len = '0;
   logic [3:0] filt_len = '0;
   logic [3:0] stride = '0;
   logic       addr_valid;
   logic       addr_ready = 1'b0;
   logic [3:0] addr_out;
   logic       win_last;
   logic       busy;
   logic       done;
   logic       cfg_err;
`ifdef IFMAP_WIN_CNT_EN
   logic [3:0] win_idx;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int exp_addr[$];
   int case1[$];

   always #5 clk = ~clk;

   ifmap_window_addr_gen #(.CONFIG_BIT(4), .NUM_OF_REG(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .ifmap_len  (ifmap_len),
      .filt_len   (filt_len),
      .stride     (stride),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .addr_out   (addr_out),
      .win_last   (win_last),
      .busy       (busy),
      .done       (done),
      .cfg_err    (cfg_err)
`ifdef IFMAP_WIN_CNT_EN
     ,.win_idx    (win_idx)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is sampled at the following posedge.
   task automatic do_start(input int sa, input int il, input int fl, input int st);
      start      = 1'b1;
      start_addr = 4'(sa);
      ifmap_len  = 4'(il);
      filt_len   = 4'(fl);
      stride     = 4'(st);
      @(negedge clk);
      start      = 1'b0;
      start_addr = 4'hF;
      ifmap_len  = 4'h0;
      filt_len   = 4'h0;
      stride     = 4'h0;
   endtask

   // Consumes exp_addr; with bp set, ready follows the pattern 1,0,0,1,0,0...
   task automatic run_pass(input int filt, input bit bp);
      int cyc = 0;
      for (int i = 0; i < exp_addr.size(); i++) begin
         bit acc = 1'b0;
         int guard = 0;
         while (!acc) begin
            chk("valid", addr_valid, 1);
            chk("addr", addr_out, exp_addr[i]);
            chk("win_last", win_last, ((i % filt) == filt - 1) ? 1 : 0);
`ifdef IFMAP_WIN_CNT_EN
            chk("win_idx", win_idx, (i / filt > 15) ? 15 : i / filt);
`endif
            addr_ready = bp ? ((cyc % 3) == 0) : 1'b1;
            acc = addr_ready;
            cyc++;
            @(negedge clk);
            guard++;
            if (!acc && guard > 8) begin
               chk("handshake_timeout", 0, 1);
               acc = 1'b1;
            end
         end
      end
      addr_ready = 1'b0;
      chk("done_pulse", done, 1);
      chk("valid_in_done", addr_valid, 0);
      chk("busy_in_done", busy, 0);
      @(negedge clk);
      chk("done_cleared", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   task automatic do_illegal(input int il, input int fl, input int st);
      do_start(3, il, fl, st);
      chk("ill_done", done, 1);
      chk("ill_valid", addr_valid, 0);
      chk("ill_cfg_err", cfg_err, 1);
      @(negedge clk);
      chk("ill_done_clr", done, 0);
      chk("ill_valid2", addr_valid, 0);
      chk("ill_cfg_err_hold", cfg_err, 1);
   endtask

   initial begin
      case1 = '{0, 1, 2, 1, 2, 3, 2, 3, 4, 3, 4, 5};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", addr_valid, 0);
      chk("rst_win_last", win_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_addr", addr_out, 0);
      rst = 1'b0;
      @(negedge clk);

      // Case 1: stride 1, no backpressure
      do_start(0, 6, 3, 1);
      exp_addr = case1;
      run_pass(3, 1'b0);

      // Case 2: wrap past the end of the scratchpad, stride 2
      do_start(14, 7, 3, 2);
      exp_addr = '{14, 15, 0, 0, 1, 2, 2, 3, 4};
      run_pass(3, 1'b0);

      // Case 3: case 1 under backpressure
      do_start(0, 6, 3, 1);
      exp_addr = case1;
      run_pass(3, 1'b1);

      // Illegal configurations
      do_illegal(4, 5, 1);
      do_illegal(6, 0, 1);
      do_illegal(6, 3, 0);

      // Legal start clears cfg_err, then async reset mid-window
      do_start(0, 6, 3, 1);
      chk("cfg_err_cleared", cfg_err, 0);
      addr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("pre_rst_addr", addr_out, case1[i]);
         @(negedge clk);
      end
      addr_ready = 1'b0;
      chk("pre_rst_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_valid", addr_valid, 0);
      chk("async_busy", busy, 0);
      chk("async_win_last", win_last, 0);
      chk("async_addr", addr_out, 0);
      chk("async_done", done, 0);
      #1 rst = 1'b0;
      @(negedge clk);

      // Restart with a new base address
      do_start(5, 6, 3, 1);
      exp_addr.delete();
      foreach (case1[i]) exp_addr.push_back((case1[i] + 5) % 16);
      run_pass(3, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
